// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : types_pkg
//  Brief    : Shared MEM/WB payload types and the write-back data selector.
//  Revision : 1.0  initial release
// ============================================================================
package types_pkg;

   // Widths of the shared payload types; mem_wb_pipe's XLEN/REG_W must agree.
   localparam int PKG_XLEN  = 64;
   localparam int PKG_REG_W = 5;

   typedef logic [PKG_XLEN-1:0]  dword_t;
   typedef logic [PKG_REG_W-1:0] reg_t;

   // Field order matters: RegWrite is the MSB of the packed word.
   typedef struct packed {
      logic   RegWrite;
      logic   MemToReg;
      reg_t   rd;
      dword_t dmemdata;
      dword_t aluout;
   } mem_wb_pkt_t;

   // Loads write back memory data, everything else writes back the ALU result.
   function automatic dword_t wb_select(input mem_wb_pkt_t p);
      return p.MemToReg ? p.dmemdata : p.aluout;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fifo
//  Brief    : DEPTH-entry circular buffer with occupancy count, synchronous
//             flush and asynchronous reset. Payload storage is not reset.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  T                       wr_data,
   output T                       rd_data,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] count;
   T                 mem [DEPTH];

   // A full or empty buffer ignores the offending request rather than corrupting state.
   logic push_ok;
   logic pop_ok;

   assign full      = (count == OCC_W'(DEPTH));
   assign empty     = (count == '0);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign occupancy = count;
   assign rd_data   = mem[rd_ptr];

   // Payload storage: written on push only, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and count: power-of-two DEPTH lets pointers wrap naturally; flush wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_pipe
//  Brief    : MEM->WB pipeline buffer with ready/valid handshakes, write-back
//             data/index/strobe generation and a wrapping retire counter.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_pipe
   import types_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int REG_W = 5,
   parameter int DEPTH = 2,   // power of two, at least 2
   parameter int CNT_W = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ihit,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  mem_wb_pkt_t            in_pkt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output mem_wb_pkt_t            out_pkt,
   output logic                   wb_we,
   output logic [REG_W-1:0]       wb_rd,
   output logic [XLEN-1:0]        wb_data,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [CNT_W-1:0]       retire_cnt
);

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Backpressure ignores ihit; ihit only gates the actual push.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready && ihit && !flush;
   assign pop       = out_valid && out_ready && !flush;

   pipe_fifo #(
      .T     (mem_wb_pkt_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .wr_data   (in_pkt),
      .rd_data   (out_pkt),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   // Write-back fields come straight off the head entry; x0 is never written.
   assign wb_data = XLEN'(wb_select(out_pkt));
   assign wb_rd   = REG_W'(out_pkt.rd);
   assign wb_we   = pop && out_pkt.RegWrite && (out_pkt.rd != '0);

   // Retire counter: one per pop, wraps naturally, untouched by flush.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         retire_cnt <= '0;
      end else if (pop) begin
         retire_cnt <= retire_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_pipe
//  Brief    : Scoreboard bench for mem_wb_pipe (DEPTH=2, CNT_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_pipe;
   import types_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        ihit;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   mem_wb_pkt_t in_pkt;
   logic        out_valid;
   logic        out_ready;
   mem_wb_pkt_t out_pkt;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic [1:0]  occupancy;
   logic [3:0]  retire_cnt;

   mem_wb_pipe #(
      .XLEN  (64),
      .REG_W (5),
      .DEPTH (DEPTH),
      .CNT_W (4)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .ihit       (ihit),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pkt     (in_pkt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pkt    (out_pkt),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .occupancy  (occupancy),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      mem_wb_pkt_t pkt;
      logic        we;
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   exp_t q[$];
   int   nchk = 0;
   int   nmis = 0;
   int   m_occ = 0;
   int   m_ret = 0;
   bit   pend_flush = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      nchk++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic mem_wb_pkt_t mk(input logic rw, input logic m2r, input logic [4:0] rd,
                                      input logic [63:0] dm, input logic [63:0] al);
      mem_wb_pkt_t p;
      p.RegWrite = rw;
      p.MemToReg = m2r;
      p.rd       = rd;
      p.dmemdata = dm;
      p.aluout   = al;
      return p;
   endfunction

   // One cycle: check state left by the previous edge, then drive the next inputs.
   task automatic step(input logic v, input logic ih, input logic ordy, input logic fl,
                       input mem_wb_pkt_t p, input logic ewe, input logic [4:0] erd,
                       input logic [63:0] edata);
      bit acc;
      bit pp;
      exp_t e;
      @(posedge clk);
      #1;
      if (pend_flush) begin
         q.delete();
         pend_flush = 0;
      end
      chk("occupancy", 160'(occupancy), 160'(m_occ));
      chk("in_ready", 160'(in_ready), 160'(m_occ < DEPTH));
      chk("out_valid", 160'(out_valid), 160'(m_occ != 0));
      chk("retire_cnt", 160'(retire_cnt), 160'(m_ret));
      in_valid  = v;
      ihit      = ih;
      out_ready = ordy;
      flush     = fl;
      in_pkt    = p;
      acc = v && ih && !fl && (m_occ < DEPTH);
      pp  = (m_occ != 0) && ordy && !fl;
      if (acc) begin
         e.pkt  = p;
         e.we   = ewe;
         e.rd   = erd;
         e.data = edata;
         q.push_back(e);
      end
      if (fl) begin
         m_occ = 0;
         pend_flush = 1;
      end else begin
         m_occ = m_occ + int'(acc) - int'(pp);
      end
      m_ret = (m_ret + int'(pp)) % 16;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b1, ordy, 1'b0, '0, 1'b0, 5'd0, 64'd0);
   endtask

   // Monitor: compare the head entry whenever the DUT presents one.
   always @(negedge clk) begin
      exp_t e;
      bit   popc;
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            nchk++;
            nmis++;
            $display("FAIL unexpected_output: got rd=%0d data=%0h expected no entry", wb_rd, wb_data);
         end else begin
            e    = q[0];
            popc = out_ready && !flush;
            chk("out_pkt", 160'(out_pkt), 160'(e.pkt));
            chk("wb_rd", 160'(wb_rd), 160'(e.rd));
            chk("wb_data", 160'(wb_data), 160'(e.data));
            chk("wb_we", 160'(wb_we), 160'(popc && e.we));
            if (popc) e = q.pop_front();
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ihit = 1'b0; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_pkt = '0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      chk("rst_occupancy", 160'(occupancy), 160'(0));
      chk("rst_retire", 160'(retire_cnt), 160'(0));
      chk("rst_wb_we", 160'(wb_we), 160'(0));
      rst = 1'b0;

      // Single ALU write-back to x5.
      step(1, 1, 1, 0, mk(1, 0, 5'd5, 64'h1111, 64'hDEAD), 1, 5'd5, 64'hDEAD);
      idle(1);
      idle(1);

      // Backpressure: fill both entries, third offer refused, then drain in order.
      step(1, 1, 0, 0, mk(1, 1, 5'd7, 64'hBEEF, 64'h5555), 1, 5'd7, 64'hBEEF);
      step(1, 1, 0, 0, mk(0, 0, 5'd9, 64'h0, 64'h77), 0, 5'd9, 64'h77);
      step(1, 1, 0, 0, mk(1, 0, 5'd3, 64'h0, 64'hBAD), 1, 5'd3, 64'hBAD);
      idle(1);
      idle(1);
      idle(1);

      // ihit low blocks pushes regardless of in_valid.
      step(1, 0, 1, 0, mk(1, 0, 5'd4, 64'h0, 64'hAAAA), 1, 5'd4, 64'hAAAA);
      step(1, 0, 1, 0, mk(1, 0, 5'd4, 64'h0, 64'hAAAA), 1, 5'd4, 64'hAAAA);
      step(1, 0, 1, 0, mk(1, 0, 5'd4, 64'h0, 64'hAAAA), 1, 5'd4, 64'hAAAA);
      step(1, 1, 1, 0, mk(1, 0, 5'd4, 64'h0, 64'hAAAA), 1, 5'd4, 64'hAAAA);
      idle(1);
      idle(1);

      // Load targeting x0: data selected from memory, strobe suppressed.
      step(1, 1, 1, 0, mk(1, 1, 5'd0, 64'h1234, 64'h9999), 0, 5'd0, 64'h1234);
      idle(1);
      idle(1);

      // Flush with a concurrent push and pop empties the buffer, retire count held.
      step(1, 1, 0, 0, mk(1, 0, 5'd31, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF), 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
      step(1, 1, 1, 1, mk(1, 0, 5'd2, 64'h0, 64'h22), 1, 5'd2, 64'h22);
      idle(1);
      idle(1);

      // Asynchronous reset mid-operation with an entry buffered.
      step(1, 1, 0, 0, mk(1, 0, 5'd6, 64'h0, 64'h66), 1, 5'd6, 64'h66);
      idle(0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 160'(out_valid), 160'(0));
      chk("arst_occupancy", 160'(occupancy), 160'(0));
      chk("arst_in_ready", 160'(in_ready), 160'(1));
      chk("arst_retire", 160'(retire_cnt), 160'(0));
      chk("arst_wb_we", 160'(wb_we), 160'(0));
      q.delete();
      m_occ = 0;
      m_ret = 0;
      pend_flush = 0;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;

      // First push after reset, then a 15-entry stream so retire_cnt passes 15 and wraps.
      step(1, 1, 1, 0, mk(1, 1, 5'd8, 64'hF00D, 64'h0), 1, 5'd8, 64'hF00D);
      for (int i = 0; i < 15; i++) begin
         step(1, 1, 1, 0, mk(1, (i % 2 == 1), 5'(i + 1), 64'h100 + 64'(i), 64'h200 + 64'(i)),
              1, 5'(i + 1), (i % 2 == 1) ? 64'h100 + 64'(i) : 64'h200 + 64'(i));
      end
      idle(1);
      idle(1);
      idle(1);
      #1;
      chk("retire_wrap", 160'(retire_cnt), 160'(0));
      chk("drained", 160'(q.size()), 160'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nmis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the data word width.
REQ-002 The block SHALL have parameter REG_W, default 5, meaning the register index width.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of buffer entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning the retire counter width.

Ports:
REQ-005 The block SHALL have one clock and an asynchronous active-high reset: CLK input 1, the clock, all state on its rising edge.
REQ-006 RST input 1: asynchronous active-high reset.
REQ-007 ihit input 1: pipeline advance enable; MEM-side pushes are accepted only while it is high.
REQ-008 flush input 1: synchronous discard of all buffered entries.
REQ-009 in_valid input 1: MEM stage offers in_pkt.
REQ-010 in_ready output 1: buffer can accept.
REQ-011 in_pkt input mem_wb_pkt_t: {RegWrite, MemToReg, rd[REG_W], dmemdata[XLEN], aluout[XLEN]}.
REQ-012 out_valid output 1: head entry present.
REQ-013 out_ready input 1: WB consumer accepts the head.
REQ-014 out_pkt output mem_wb_pkt_t: head entry fields.
REQ-015 wb_we output 1: register-file write strobe.
REQ-016 wb_rd output REG_W: write-back register index.
REQ-017 wb_data output XLEN: write-back data.
REQ-018 occupancy output $clog2(DEPTH)+1: current entry count.
REQ-019 retire_cnt output CNT_W: total entries popped.

Function
REQ-020 Storage SHALL be a DEPTH-entry circular FIFO with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-021 in_ready SHALL be 1 iff occupancy < DEPTH, regardless of ihit.
REQ-022 A push SHALL occur iff in_valid && in_ready && ihit && !flush.
REQ-023 A pop SHALL occur iff out_valid && out_ready && !flush.
REQ-024 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_valid/out_pkt after edge N.
REQ-025 out_valid SHALL be 1 iff occupancy != 0; out_pkt SHALL be the entry at rd_ptr, combinational from storage.
REQ-026 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-027 A push while full SHALL be impossible, because in_ready=0; a pop while empty SHALL be impossible, because out_valid=0.
REQ-028 flush SHALL set occupancy and both pointers to 0 at the next edge, overriding any same-cycle push or pop; retire_cnt SHALL be unaffected.
REQ-029 wb_data SHALL be out_pkt.MemToReg ? out_pkt.dmemdata : out_pkt.aluout.
REQ-030 wb_rd SHALL equal out_pkt.rd.
REQ-031 wb_we SHALL be the pop condition AND out_pkt.RegWrite AND (out_pkt.rd != 0), so x0 is never written.
REQ-032 retire_cnt SHALL increment by 1 on each pop and wrap from 2^CNT_W-1 to 0.
REQ-033 Entry payload registers SHALL NOT require reset; only pointers, occupancy and retire_cnt are reset.

Reset
REQ-034 Asserting RST SHALL immediately, without waiting for CLK, force pointers=0, occupancy=0, retire_cnt=0, out_valid=0, wb_we=0 and in_ready=1.
REQ-035 RST asserted mid-operation SHALL drop all buffered entries; the first push after RST deasserts SHALL land in entry 0.

Structure
REQ-036 mem_wb_pkt_t, reg_t and dword_t SHALL live in types_pkg; DEPTH, CNT_W and the derived pointer widths stay local parameters.
REQ-037 One sub-module, pipe_fifo (parametrised by payload type and DEPTH, holding pointers, storage and occupancy), SHALL be instantiated; write-back muxing and the retire counter stay in mem_wb_pipe.

Verification
REQ-038 Reset, then push {RegWrite=1, MemToReg=0, rd=5, aluout=0xDEAD} with ihit=1 and out_ready=1 -> next cycle out_valid=1, wb_we=1, wb_rd=5, wb_data=0xDEAD, retire_cnt=1.
REQ-039 Hold out_ready=0 and push 2 entries (DEPTH=2) -> occupancy=2 and in_ready=0; a third in_valid is not accepted; then release out_ready -> the entries drain in order over 2 cycles.
REQ-040 ihit=0 with in_valid=1 for 3 cycles -> occupancy stays 0; ihit=1 -> push accepted.
REQ-041 Push {RegWrite=1, rd=0, MemToReg=1, dmemdata=0x1234} -> out_valid=1, wb_data=0x1234, wb_we=0.
REQ-042 occupancy=1, then flush asserted together with a push and a pop -> next cycle occupancy=0, out_valid=0, retire_cnt unchanged.
REQ-043 CNT_W=4, pop 16 entries -> retire_cnt reads 15 and then 0; asserting RST asynchronously mid-stream -> out_valid=0 before the next edge.
